// File: rtl/nixie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nixie_pkg
// Description : Shared constants for the nixie tube multiplex scheduler:
//               tube count, largest displayable BCD digit, slot phase
//               encoding and the field layout of the driver value byte.
// Revision    : 1.0  initial release
// ============================================================================
package nixie_pkg;

    localparam int NUM_TUBES = 6;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Slot phase encoding
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    // Driver value byte layout: {3'b000, dp, bcd[3:0]}
    localparam int VAL_BCD_LSB = 0;
    localparam int VAL_DP_BIT  = 4;

    function automatic logic [7:0] pack_value(input logic dp, input logic [3:0] bcd);
        logic [7:0] v;
        v                       = 8'h00;
        v[VAL_BCD_LSB +: 4]     = bcd;
        v[VAL_DP_BIT]           = dp;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nixie_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : nixie_slot_timer
// Description : Slot timebase. Each tube slot is BLANK_CYCLES of dark time
//               followed by ON_CYCLES of ON window; tube index walks 0..5.
//               The state/count/index outputs describe the cycle currently
//               being evaluated; the top registers its outputs from them,
//               so the displayed effect lines up one register stage later.
// Ports       : clk, rst          clock, async active-high reset
//               state_o           ST_BLANK / ST_ON
//               cnt_o             cycle count within the current phase
//               idx_o             active tube index
//               frame_start_o     first BLANK cycle of tube 0
//               slot_start_o      first BLANK cycle of any tube
//               frame_pulse_o     registered pulse, last ON cycle of tube 5
// Revision    : 1.0  initial release
// ============================================================================
module nixie_slot_timer
    import nixie_pkg::*;
#(
    parameter int BLANK_CYCLES = 10_000,
    parameter int ON_CYCLES    = 100_000,
    parameter int CW           = 17
) (
    input  logic          clk,
    input  logic          rst,
    output logic [0:0]    state_o,
    output logic [CW-1:0] cnt_o,
    output logic [2:0]    idx_o,
    output logic          frame_start_o,
    output logic          slot_start_o,
    output logic          frame_pulse_o
);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    idx_q,   idx_d;
    logic          frame_pulse_q;
    logic          w_last_on;

    assign w_last_on = (state_q == ST_ON) && (cnt_q == CW'(ON_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        if (state_q == ST_BLANK) begin
            if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        end else if (w_last_on) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == 3'(NUM_TUBES - 1)) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            frame_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_pulse_q <= w_last_on && (idx_q == 3'(NUM_TUBES - 1));
        end
    end

    assign state_o       = state_q;
    assign cnt_o         = cnt_q;
    assign idx_o         = idx_q;
    assign slot_start_o  = (state_q == ST_BLANK) && (cnt_q == '0);
    assign frame_start_o = slot_start_o && (idx_q == 3'd0);
    assign frame_pulse_o = frame_pulse_q;

endmodule
`default_nettype wire

// File: rtl/nixie_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : nixie_mux_scheduler
// Description : Time-multiplexes six nixie tubes with a blanking gap per
//               slot, PWM brightness, per-frame input snapshot and an
//               on-demand anti-cathode-poisoning sweep (0..9 on all tubes).
// Ports       : clk, rst              clock, async active-high reset
//               digits_i[23:0]        BCD per tube, tube i = [4i+3:4i]
//               dp_i[5:0]             decimal point per tube
//               brightness_i[2:0]     on-time = (b+1)/8 of ON window
//               blank_all_i           force all enables low
//               sweep_req_i           request an anti-poisoning sweep
//               nixieEnable_o[5:0]    one-hot tube enable
//               nixieValue_o[7:0]     {3'b000, dp, bcd}
//               frame_pulse_o         last cycle of tube 5 ON window
//               sweep_busy_o          sweep frames being displayed
// Revision    : 1.0  initial release
// ============================================================================
module nixie_mux_scheduler
    import nixie_pkg::*;
#(
    parameter int BLANK_CYCLES = 10_000,
    parameter int ON_CYCLES    = 100_000,
    parameter int SWEEP_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] digits_i,
    input  logic [5:0]  dp_i,
    input  logic [2:0]  brightness_i,
    input  logic        blank_all_i,
    input  logic        sweep_req_i,
    output logic [5:0]  nixieEnable_o,
    output logic [7:0]  nixieValue_o,
    output logic        frame_pulse_o,
    output logic        sweep_busy_o
);

    localparam int CNT_MAX = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SFW     = $clog2(SWEEP_FRAMES + 1);

    logic [0:0]    w_state;
    logic [CW-1:0] w_cnt;
    logic [2:0]    w_idx;
    logic          w_frame_start;
    logic          w_slot_start;

    nixie_slot_timer #(
        .BLANK_CYCLES (BLANK_CYCLES),
        .ON_CYCLES    (ON_CYCLES),
        .CW           (CW)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .state_o       (w_state),
        .cnt_o         (w_cnt),
        .idx_o         (w_idx),
        .frame_start_o (w_frame_start),
        .slot_start_o  (w_slot_start),
        .frame_pulse_o (frame_pulse_o)
    );

    // Snapshot registers; the frame-start cycle uses the live inputs so that
    // the very first slot of a frame already shows the fresh snapshot.
    logic [23:0] digits_q;
    logic [5:0]  dp_q;
    logic [2:0]  bright_q;
    logic [23:0] w_digits;
    logic [5:0]  w_dp;
    logic [2:0]  w_bright;

    assign w_digits = w_frame_start ? digits_i     : digits_q;
    assign w_dp     = w_frame_start ? dp_i         : dp_q;
    assign w_bright = w_frame_start ? brightness_i : bright_q;

    // Sweep control; all changes of the active sweep happen at a frame start.
    logic           busy_q, busy_d;
    logic           pend_q, pend_d;
    logic [3:0]     sdig_q, sdig_d;
    logic [SFW-1:0] sfrm_q, sfrm_d;

    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        sdig_d = sdig_q;
        sfrm_d = sfrm_q;
        if (w_frame_start) begin
            if (busy_q) begin
                if (sfrm_q == SFW'(SWEEP_FRAMES - 1)) begin
                    sfrm_d = '0;
                    if (sdig_q == BCD_MAX) begin
                        busy_d = 1'b0;
                    end else begin
                        sdig_d = sdig_q + 4'd1;
                    end
                end else begin
                    sfrm_d = sfrm_q + SFW'(1);
                end
            end else if (pend_q) begin
                busy_d = 1'b1;
                pend_d = 1'b0;
                sdig_d = 4'd0;
                sfrm_d = '0;
            end
        end
        // Evaluated against the pre-boundary state, so a request landing on
        // the boundary cycle waits for the following frame.
        if (sweep_req_i && !busy_q && !pend_q) begin
            pend_d = 1'b1;
        end
    end

    // Slot value selection
    logic [3:0] w_bcd_sel;
    logic       w_dp_sel;
    logic [7:0] value_q, value_d;

    always_comb begin
        w_bcd_sel = 4'd0;
        w_dp_sel  = 1'b0;
        for (int t = 0; t < NUM_TUBES; t++) begin
            if (w_idx == 3'(t)) begin
                w_bcd_sel = w_digits[4*t +: 4];
                w_dp_sel  = w_dp[t];
            end
        end
        if (busy_d) begin
            w_bcd_sel = sdig_d;
            w_dp_sel  = 1'b0;
        end
        value_d = w_slot_start ? pack_value(w_dp_sel, w_bcd_sel) : value_q;
    end

    // PWM: value_q is stable for the whole ON window of the slot, so its BCD
    // field doubles as the out-of-range (dark tube) check.
    int         w_on_len;
    logic       w_lit;
    logic [5:0] en_d;

    always_comb begin
        w_on_len = (int'(bright_q) + 1) * (ON_CYCLES / 8);
        w_lit    = (w_state == ST_ON) && (int'(w_cnt) < w_on_len) &&
                   !blank_all_i && (value_q[VAL_BCD_LSB +: 4] <= BCD_MAX);
        en_d     = '0;
        for (int t = 0; t < NUM_TUBES; t++) begin
            en_d[t] = w_lit && (w_idx == 3'(t));
        end
    end

    logic [5:0] en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
            dp_q     <= '0;
            bright_q <= '0;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            sdig_q   <= 4'd0;
            sfrm_q   <= '0;
            value_q  <= 8'h00;
            en_q     <= '0;
        end else begin
            digits_q <= w_digits;
            dp_q     <= w_dp;
            bright_q <= w_bright;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            sdig_q   <= sdig_d;
            sfrm_q   <= sfrm_d;
            value_q  <= value_d;
            en_q     <= en_d;
        end
    end

    assign nixieEnable_o = en_q;
    assign nixieValue_o  = value_q;
    assign sweep_busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nixie_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_nixie_mux_scheduler
// Description : Self-checking bench. A frame/slot arithmetic model predicts
//               all outputs every cycle; directed literal checks pin the
//               model to hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nixie_mux_scheduler;

    localparam int BLANK = 2;
    localparam int ON    = 8;
    localparam int SWF   = 1;
    localparam int P     = BLANK + ON;
    localparam int FRAME = 6 * P;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [2:0]  brightness;
    logic        blank_all;
    logic        sweep_req;
    logic [5:0]  en;
    logic [7:0]  val;
    logic        fp;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cur_cyc;

    // Model state
    int          m_k;
    logic [23:0] m_digits;
    logic [5:0]  m_dp;
    logic [2:0]  m_bright;
    bit          m_pending;
    bit          m_active;
    int          m_frames;
    logic [5:0]  x_en;
    logic [7:0]  x_val;
    logic        x_fp;
    logic        x_busy;

    always #5 clk = ~clk;

    nixie_mux_scheduler #(
        .BLANK_CYCLES (BLANK),
        .ON_CYCLES    (ON),
        .SWEEP_FRAMES (SWF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .digits_i      (digits),
        .dp_i          (dp),
        .brightness_i  (brightness),
        .blank_all_i   (blank_all),
        .sweep_req_i   (sweep_req),
        .nixieEnable_o (en),
        .nixieValue_o  (val),
        .frame_pulse_o (fp),
        .sweep_busy_o  (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cur_cyc, act, exp);
        end
    endtask

    // Expected outputs for cycle m_k from frame/slot arithmetic.
    task automatic model_step();
        int pos, slot, off;
        bit accept;
        pos    = m_k % FRAME;
        slot   = pos / P;
        off    = pos % P;
        accept = sweep_req && !m_active && !m_pending;
        if (pos == 0) begin
            m_digits = digits;
            m_dp     = dp;
            m_bright = brightness;
            if (m_active) begin
                m_frames++;
                if (m_frames == 10 * SWF) m_active = 1'b0;
            end else if (m_pending) begin
                m_active  = 1'b1;
                m_frames  = 0;
                m_pending = 1'b0;
            end
        end
        if (accept) m_pending = 1'b1;
        if (m_active) x_val = {4'b0000, 4'(m_frames / SWF)};
        else          x_val = {3'b000, m_dp[slot], m_digits[slot*4 +: 4]};
        x_en = '0;
        if (off >= BLANK && (off - BLANK) < (int'(m_bright) + 1) * ON / 8 &&
            !blank_all && x_val[3:0] <= 4'd9)
            x_en[slot] = 1'b1;
        x_fp   = (slot == 5) && (off == P - 1);
        x_busy = m_active;
        m_k++;
    endtask

    task automatic literal(input int scn, input int c);
        case (scn)
            1, 6: begin
                if (c == 0)   begin check("s1_en0", en, 6'b0); check("s1_val0", val, 8'h06); end
                if (c == 1)   check("s1_en1", en, 6'b0);
                if (c == 2)   check("s1_en2", en, 6'b000001);
                if (c == 9)   check("s1_en9", en, 6'b000001);
                if (c == 10)  begin check("s1_val10", val, 8'h05); check("s1_en10", en, 6'b0); end
                if (c == 19)  check("s1_val19", val, 8'h05);
                if (c == 58)  check("s1_fp58", fp, 1'b0);
                if (c == 59)  check("s1_fp59", fp, 1'b1);
                if (c == 119) check("s1_fp119", fp, 1'b1);
            end
            2: begin
                if (c == 2)  check("s2_en2", en, 6'b000001);
                if (c == 3)  check("s2_en3", en, 6'b000001);
                if (c == 4)  check("s2_en4", en, 6'b0);
                if (c == 12) check("s2_en12", en, 6'b000010);
                if (c == 14) check("s2_en14", en, 6'b0);
            end
            3: begin
                if (c == 20) check("s3_val20", val, 8'h0A);
                if (c == 22) check("s3_en22", en, 6'b0);
                if (c == 32) check("s3_en32", en, 6'b001000);
            end
            4: begin
                if (c == 59)  check("s4_busy59", busy, 1'b0);
                if (c == 60)  begin check("s4_busy60", busy, 1'b1); check("s4_val60", val, 8'h00); end
                if (c == 120) check("s4_val120", val, 8'h01);
                if (c == 659) begin check("s4_busy659", busy, 1'b1); check("s4_val659", val, 8'h09); end
                if (c == 660) begin check("s4_busy660", busy, 1'b0); check("s4_val660", val, 8'h06); end
                if (c == 779) check("s4_busy779", busy, 1'b0);
            end
            5: begin
                if (c == 20)  check("s5_val20", val, 8'h14);
                if (c == 40)  check("s5_val40", val, 8'h02);
                if (c == 60)  check("s5_val60", val, 8'h01);
                if (c == 100) check("s5_val100", val, 8'h05);
                if (c == 72)  check("s5_en72", en, 6'b0);
                if (c == 82)  check("s5_en82", en, 6'b0);
                if (c == 92)  check("s5_en92", en, 6'b001000);
                if (c == 119) check("s5_fp119", fp, 1'b1);
            end
            default: ;
        endcase
    endtask

    task automatic run(input int scn, input int ncyc);
        rst        = 1'b1;
        digits     = (scn == 3) ? 24'h123A56 : 24'h123456;
        dp         = (scn == 5) ? 6'b000100 : 6'b000000;
        brightness = (scn == 2) ? 3'd1 : 3'd7;
        blank_all  = 1'b0;
        sweep_req  = 1'b0;
        repeat (2) @(negedge clk);
        cur_cyc = -1;
        check("rst_en", en, 6'b0);
        check("rst_val", val, 8'h00);
        check("rst_fp", fp, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst       = 1'b0;
        m_k       = 0;
        m_pending = 1'b0;
        m_active  = 1'b0;
        m_frames  = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            cur_cyc = c;
            model_step();
            check("model_en", en, x_en);
            check("model_val", val, x_val);
            check("model_fp", fp, x_fp);
            check("model_busy", busy, x_busy);
            literal(scn, c);
            @(negedge clk);
            if (scn == 4) sweep_req = (c == 25) || (c == 200);
            if (scn == 5) begin
                if (c == 30) digits = 24'h654321;
                blank_all = (c >= 70) && (c <= 90);
            end
            if (scn == 6 && c == 5) begin
                rst = 1'b1;
                #1;
                check("s6_async_en", en, 6'b0);
                check("s6_async_val", val, 8'h00);
                check("s6_async_fp", fp, 1'b0);
                check("s6_async_busy", busy, 1'b0);
            end
        end
    endtask

    initial begin
        run(1, 120);
        run(2, 60);
        run(3, 60);
        run(4, 780);
        run(5, 130);
        run(6, 6);
        run(1, 120);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
